serial_tx_arbiter: RTL and testbench

- Transmit-side controller for the serial link: round-robin arbitration among four parallel requesters for the single serial output line.
- Sequences one framed transfer per grant:
  - start bit
  - 2-bit port id
  - 4-bit length
  - `length` data bits
- Produces the same frame format the link's receive controller decodes, so a transmitter and receiver can be wired back-to-back.
- Internal counters and shift registers are owned by this block; no external datapath is required.

---
 rtl/serial_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_serial_tx_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter of four requesters onto one framed serial line.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit (PAR state) to every frame.
module serial_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clk_en,
    input  logic [NREQ-1:0]   i_req,
    input  logic [4*NREQ-1:0] i_len,
    input  logic [DW*NREQ-1:0] i_data,
    output logic [NREQ-1:0]   o_ack,
    output logic              o_ser_out,
    output logic              o_ser_out_valid,
    output logic              o_busy,
    output logic              o_done
);
    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, PAR, DONE} state_t;
`ifdef SERIAL_TX_PARITY_EN
    localparam state_t TAIL = PAR;
`else
    localparam state_t TAIL = DONE;
`endif
    state_t          r_state, w_next;
    logic [1:0]      r_rr, r_id, w_gnt_id;
    logic [3:0]      r_len, r_cnt, w_len_sel;
    logic [DW-1:0]   r_data, w_data_sel;
    logic [NREQ-1:0] r_ack;
`ifdef SERIAL_TX_PARITY_EN
    logic            r_par;
    logic [DW-1:0]   w_mask;
    assign w_mask = ~({DW{1'b1}} << w_len_sel);
`endif
    // Descending scan so the requester closest to r_rr wins.
    always_comb begin
        w_gnt_id = r_rr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (i_req[r_rr + 2'(k)]) w_gnt_id = r_rr + 2'(k);
    end
    assign w_len_sel  = i_len[{w_gnt_id, 2'b00} +: 4];
    assign w_data_sel = i_data[DW*w_gnt_id +: DW];
    assign o_ack      = r_ack;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else if (i_clk_en) r_state <= w_next;
    always_comb begin
        w_next          = r_state;
        o_ser_out       = 1'b1;
        o_ser_out_valid = 1'b0;
        o_busy          = 1'b1;
        o_done          = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                w_next = |i_req ? START : IDLE;
            end
            START: begin
                o_ser_out = 1'b0;
                w_next    = PORT;
            end
            PORT: begin
                o_ser_out = r_id[r_cnt[0]];
                w_next    = r_cnt == 4'd0 ? LEN : PORT;
            end
            LEN: begin
                o_ser_out = r_len[r_cnt[1:0]];
                w_next    = r_cnt != 4'd0 ? LEN : r_len == 4'd0 ? TAIL : DATA;
            end
            DATA: begin
                o_ser_out       = r_data[0];
                o_ser_out_valid = 1'b1;
                w_next          = r_cnt == 4'd1 ? TAIL : DATA;
            end
`ifdef SERIAL_TX_PARITY_EN
            PAR: begin
                o_ser_out = r_par;
                w_next    = DONE;
            end
`endif
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = IDLE;
            end
        endcase
    end
    // r_cnt: id/length bit index in PORT/LEN, remaining data bits in DATA.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_ack  <= '0;
            r_rr   <= '0;
            r_id   <= '0;
            r_len  <= '0;
            r_data <= '0;
            r_cnt  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            if (i_clk_en)
                case (r_state)
                    IDLE: if (|i_req) begin
                        r_ack  <= NREQ'(1) << w_gnt_id;
                        r_rr   <= w_gnt_id + 2'd1;
                        r_id   <= w_gnt_id;
                        r_len  <= w_len_sel;
                        r_data <= w_data_sel;
                        r_cnt  <= 4'd1;
`ifdef SERIAL_TX_PARITY_EN
                        r_par  <= ^{w_gnt_id, w_len_sel, w_data_sel & w_mask};
`endif
                    end
                    PORT: r_cnt <= r_cnt == 4'd0 ? 4'd3 : r_cnt - 4'd1;
                    LEN:  r_cnt <= r_cnt == 4'd0 ? r_len : r_cnt - 4'd1;
                    DATA: begin
                        r_cnt  <= r_cnt - 4'd1;
                        r_data <= r_data >> 1;
                    end
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench for serial_tx_arbiter; frames are written
// as bit strings in send order (leftmost bit first on the line).
module tb_serial_tx_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] len_in = '0;
    logic [59:0] data_in = '0;
    logic [3:0]  ack;
    logic        ser_out, ser_valid, busy, done;
    int total = 0, bad = 0, div = 1, ph = 0;
    typedef struct {
        logic [1:0]  id;
        int          n;
        logic [31:0] bits;
        logic [31:0] vmask;
    } frame_t;
    frame_t exp_q[$];

    serial_tx_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_req(req),
        .i_len(len_in), .i_data(data_in), .o_ack(ack), .o_ser_out(ser_out),
        .o_ser_out_valid(ser_valid), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ph = (ph + 1 >= div) ? 0 : ph + 1;
        clk_en = (ph == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic push(input logic [1:0] id, input int n, input logic [31:0] bits, input logic [31:0] vmask);
        frame_t f;
        f.id = id; f.n = n; f.bits = bits; f.vmask = vmask;
`ifdef SERIAL_TX_PARITY_EN
        f.bits = {bits[30:0], ^bits}; f.n = n + 1; f.vmask = vmask << 1;
`endif
        exp_q.push_back(f);
    endtask

    task automatic set_op(input int i, input logic [3:0] len, input logic [14:0] data);
        len_in[4*i +: 4]   = len;
        data_in[15*i +: 15] = data;
    endtask

    task automatic wait_ack(input int n);
        int got = 0;
        for (int c = 0; c < 1000 && got < n; c++) begin
            @(negedge clk);
            if (ack != 0) got++;
        end
        check("ack_count", got, n);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000 && !(exp_q.size() == 0 && !busy); c++) @(negedge clk);
        check("drain", exp_q.size() + int'(busy), 0);
    endtask

    // Monitor: collects frame bits on clkEn cycles, scores them on Done.
    initial begin
        logic e;
        logic [3:0] pa;
        logic ls, lb;
        logic [31:0] col, vcol;
        int cnt;
        logic [1:0] aid;
        frame_t f;
        pa = '0; ls = 1'b1; lb = 1'b0; col = '0; vcol = '0; cnt = 0; aid = '0;
        forever begin
            @(posedge clk);
            e = clk_en;
            @(negedge clk);
            if (!rst_n) begin
                col = '0; vcol = '0; cnt = 0; pa = '0; ls = 1'b1; lb = 1'b0;
            end else begin
                if (ack != 0) begin
                    check("ack_onehot", 32'($onehot(ack)), 1);
                    check("ack_width", pa, 0);
                    aid = ack[3] ? 2'd3 : ack[2] ? 2'd2 : ack[1] ? 2'd1 : 2'd0;
                end
                pa = ack;
                if (!e) check("hold", {ser_out, busy}, {ls, lb});
                else if (done) begin
                    if (exp_q.size() == 0) check("unexpected_frame", exp_q.size(), 1);
                    else begin
                        f = exp_q.pop_front();
                        check("frame_id", aid, f.id);
                        check("frame_len", cnt, f.n);
                        check("frame_bits", col, f.bits);
                        check("frame_valid", vcol, f.vmask);
                    end
                    col = '0; vcol = '0; cnt = 0;
                end else if (busy) begin
                    col = {col[30:0], ser_out};
                    vcol = {vcol[30:0], ser_valid};
                    cnt++;
                end else check("idle_line", {ser_out, ser_valid}, 2'b10);
                ls = ser_out; lb = busy;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outs", {ser_out, ser_valid, busy, done, ack}, 8'b1000_0000);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle", {ser_out, busy, done, ack}, 7'b100_0000);
        end
        // all four held: grants 0,1,2,3,0
        set_op(0, 4'd1, 15'd1); set_op(1, 4'd2, 15'd2); set_op(2, 4'd3, 15'd5); set_op(3, 4'd4, 15'd6);
        push(0, 8, 32'b00000011, 32'b1);
        push(1, 9, 32'b001001001, 32'b11);
        push(2, 10, 32'b0100011101, 32'b111);
        push(3, 11, 32'b01101000110, 32'b1111);
        push(0, 8, 32'b00000011, 32'b1);
        req = 4'b1111; wait_ack(5); req = '0; wait_drain();
        // single request, len 3, data 101
        push(2, 10, 32'b0100011101, 32'b111);
        req = 4'b0100; wait_ack(1); req = '0; wait_drain();
        // zero length: no data field
        set_op(0, 4'd0, 15'h7fff);
        push(0, 7, 32'b0, 32'b0);
        req = 4'b0001; wait_ack(1); req = '0; wait_drain();
        // data bits above length-1 ignored
        set_op(1, 4'd2, 15'h7ffe);
        push(1, 9, 32'b001001001, 32'b11);
        req = 4'b0010; wait_ack(1); req = '0; wait_drain();
        // maximum length
        set_op(3, 4'd15, 15'h5a3c);
        push(3, 22, 32'b0111111_001111000101101, 32'h7fff);
        req = 4'b1000; wait_ack(1); req = '0; wait_drain();
        // sparse clkEn
        div = 3;
        set_op(2, 4'd3, 15'd5);
        push(2, 10, 32'b0100011101, 32'b111);
        req = 4'b0100; wait_ack(1); req = '0; wait_drain();
        div = 1;
        // reset in DATA: aborted frame, rr back to 0
        set_op(1, 4'd10, 15'h3ff);
        req = 4'b0010; wait_ack(1); req = '0;
        for (int c = 0; c < 200 && !ser_valid; c++) @(negedge clk);
        check("reach_data", ser_valid, 1);
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {ser_out, ser_valid, busy, done, ack}, 8'b1000_0000);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        set_op(0, 4'd1, 15'd1); set_op(2, 4'd3, 15'd5);
        push(0, 8, 32'b00000011, 32'b1);
        push(2, 10, 32'b0100011101, 32'b111);
        req = 4'b0101; wait_ack(1); req = 4'b0100; wait_ack(1); req = '0; wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
